// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes, channel FSM states and bus widths
package axi_lite_pkg;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
endpackage

// File: rtl/axi_delay_lfsr.sv
// axi_delay_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) for response jitter
module axi_delay_lfsr (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    // shift every cycle, feedback is the XOR of taps 8,6,5,4
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 8'hA5;
        else q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite responder over a word SRAM; AXI_SRAM_RAND_DELAY_EN adds 0..7 random wait cycles
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int unsigned       LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * MEM_WORDS);
`ifdef AXI_SRAM_RAND_DELAY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    if (LATENCY > 15) begin : g_latency_check
        $error("LATENCY must be in 0..15");
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a >= BASE_ADDR && (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [CNT_W-1:0] delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    axi_delay_lfsr u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
    assign delay = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
    assign delay = CNT_W'(LATENCY);
`endif

    r_state_t r_state, r_next;
    logic [CNT_W-1:0] r_cnt, r_cnt_next;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_c;
    logic ar_hs, r_enter;

    assign arready = r_state == R_IDLE;
    assign rvalid = r_state == R_RESP;
    assign ar_hs = arvalid && arready;
    assign ar_addr_c = ar_hs ? araddr : ar_addr_q;
    assign r_enter = r_next == R_RESP && r_state != R_RESP;

    // read channel: capture address, count down the wait, hold the response until accepted
    always_comb begin
        r_next = r_state;
        r_cnt_next = r_cnt;
        if (r_state == R_IDLE && ar_hs) begin
            r_next = delay == '0 ? R_RESP : R_WAIT;
            r_cnt_next = delay;
        end else if (r_state == R_WAIT) begin
            r_next = r_cnt == CNT_W'(1) ? R_RESP : R_WAIT;
            r_cnt_next = r_cnt - CNT_W'(1);
        end else if (r_state == R_RESP && rready) begin
            r_next = R_IDLE;
        end
    end

    // read state, captured address and response registers sampled on entry to R_RESP
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt <= '0;
            ar_addr_q <= '0;
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            r_cnt <= r_cnt_next;
            if (ar_hs) ar_addr_q <= araddr;
            if (r_enter) begin
                rdata <= in_range(ar_addr_c) ? mem[idx(ar_addr_c)] : '0;
                rresp <= in_range(ar_addr_c) ? RESP_OKAY : RESP_SLVERR;
            end
        end

    w_state_t w_state, w_next;
    logic [CNT_W-1:0] w_cnt, w_cnt_next;
    logic aw_held, w_held, aw_hs, w_hs, w_enter;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_c;
    logic [DATA_W-1:0] wdata_q, wdata_c;
    logic [STRB_W-1:0] wstrb_q, wstrb_c;

    assign awready = w_state == W_IDLE && !aw_held;
    assign wready = w_state == W_IDLE && !w_held;
    assign bvalid = w_state == W_RESP;
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign aw_addr_c = aw_hs ? awaddr : aw_addr_q;
    assign wdata_c = w_hs ? wdata : wdata_q;
    assign wstrb_c = w_hs ? wstrb : wstrb_q;
    assign w_enter = w_next == W_RESP && w_state != W_RESP;

    // write channel: wait for both AW and W, count down, hold the response until accepted
    always_comb begin
        w_next = w_state;
        w_cnt_next = w_cnt;
        if (w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs)) begin
            w_next = delay == '0 ? W_RESP : W_WAIT;
            w_cnt_next = delay;
        end else if (w_state == W_WAIT) begin
            w_next = w_cnt == CNT_W'(1) ? W_RESP : W_WAIT;
            w_cnt_next = w_cnt - CNT_W'(1);
        end else if (w_state == W_RESP && bready) begin
            w_next = W_IDLE;
        end
    end

    // write state, captured AW/W beats and the response code set at commit time
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt <= '0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            w_cnt <= w_cnt_next;
            aw_held <= (w_state == W_RESP && bready) ? 1'b0 : aw_held || aw_hs;
            w_held <= (w_state == W_RESP && bready) ? 1'b0 : w_held || w_hs;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_enter) bresp <= in_range(aw_addr_c) ? RESP_OKAY : RESP_SLVERR;
        end

    // SRAM array is never reset; strobed bytes land as the write response is produced
    always_ff @(posedge clk)
        if (w_enter && in_range(aw_addr_c))
            for (int i = 0; i < STRB_W; i++)
                if (wstrb_c[i]) mem[idx(aw_addr_c)][8*i +: 8] <= wdata_c[8*i +: 8];
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave: vector table, corner-case sequences and a randomized scoreboard run
module tb_axi_lite_sram_slave;
    localparam int LAT = 1;
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef AXI_SRAM_RAND_DELAY_EN
    localparam int LAT_MAX = LAT + 8;
`else
    localparam int LAT_MAX = LAT + 1;
`endif

    logic clk = 0, rst = 1;
    logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
    logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
    logic arready, rvalid, awready, wready, bvalid;
    logic [3:0] wstrb = 0;
    logic [1:0] rresp, bresp;
    int checks = 0, errors = 0;

    axi_lite_sram_slave #(.ADDR_W(32), .MEM_WORDS(4096), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
        checks++;
        if (lat < LAT + 1 || lat > LAT_MAX) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d..%0d", name, lat, LAT + 1, LAT_MAX);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n = 0;
        araddr = a;
        arvalid = 1;
        rready = 1;
        while (!arready && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 0;
        lat = 1;
        while (!rvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        d = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int n = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1;
        wvalid = 1;
        bready = 1;
        while ((awvalid || wvalid) && n < 64) begin
            logic ha, hw;
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(negedge clk);
            n++;
            if (ha) awvalid = 0;
            if (hw) wvalid = 0;
        end
        lat = 1;
        while (!bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        resp = bresp;
        @(negedge clk);
        bready = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t tbl [17];
    logic [31:0] model [16];

    initial begin
        logic [31:0] d;
        logic [1:0] resp;
        int lat, n;

        tbl[0]  = '{1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00};
        tbl[1]  = '{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00};
        tbl[2]  = '{0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00};
        tbl[3]  = '{1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 2'b00};
        tbl[4]  = '{1, 32'h8000_0020, 32'h1122_3344, 4'h5, 2'b00};
        tbl[5]  = '{0, 32'h8000_0020, 32'hFF22_FF44, 4'h0, 2'b00};
        tbl[6]  = '{1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 2'b10};
        tbl[7]  = '{0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 2'b10};
        tbl[8]  = '{0, 32'h8000_0000, 32'hCAFE_F00D, 4'h0, 2'b00};
        tbl[9]  = '{1, 32'h8000_0010, 32'h0000_0000, 4'h0, 2'b00};
        tbl[10] = '{0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00};
        tbl[11] = '{1, 32'h8000_3FFE, 32'h0A0B_0C0D, 4'hF, 2'b00};
        tbl[12] = '{0, 32'h8000_3FFC, 32'h0A0B_0C0D, 4'h0, 2'b00};
        tbl[13] = '{1, 32'h8000_4000, 32'h5555_AAAA, 4'hF, 2'b10};
        tbl[14] = '{0, 32'h8000_4000, 32'h0000_0000, 4'h0, 2'b10};
        tbl[15] = '{0, 32'h8000_0012, 32'hDEAD_BEEF, 4'h0, 2'b00};
        tbl[16] = '{0, 32'h8000_0000, 32'hCAFE_F00D, 4'h0, 2'b00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset arready", 32'(arready), 1);
        check("reset awready", 32'(awready), 1);
        check("reset wready", 32'(wready), 1);
        check("reset rvalid", 32'(rvalid), 0);
        check("reset bvalid", 32'(bvalid), 0);
        check("reset rdata", rdata, 0);
        check("reset rresp", 32'(rresp), 0);
        check("reset bresp", 32'(bresp), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, lat);
                check($sformatf("vec%0d bresp", i), 32'(resp), 32'(tbl[i].resp));
                check_lat($sformatf("vec%0d write", i), lat);
            end else begin
                do_read(tbl[i].addr, d, resp, lat);
                check($sformatf("vec%0d rresp", i), 32'(resp), 32'(tbl[i].resp));
                check($sformatf("vec%0d rdata", i), d, tbl[i].data);
                check_lat($sformatf("vec%0d read", i), lat);
            end
        end

        // W leads AW by 3 cycles, B held off for 5 cycles
        wdata = 32'h55AA_55AA;
        wstrb = 4'hF;
        awaddr = 32'h8000_0030;
        wvalid = 1;
        check("wlead wready before", 32'(wready), 1);
        @(negedge clk);
        wvalid = 0;
        check("wlead wready dropped", 32'(wready), 0);
        check("wlead awready still", 32'(awready), 1);
        repeat (2) @(negedge clk);
        awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        lat = 1;
        while (!bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_lat("wlead write", lat);
        check("wlead bresp", 32'(bresp), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wlead bvalid held", 32'(bvalid), 1);
            check("wlead bresp held", 32'(bresp), 0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("wlead awready after B", 32'(awready), 1);
        check("wlead wready after B", 32'(wready), 1);
        check("wlead bvalid after B", 32'(bvalid), 0);
        do_read(32'h8000_0030, d, resp, lat);
        check("wlead readback", d, 32'h55AA_55AA);

        // same-cycle read and write of one word: read must see the old value
        do_write(32'h8000_0040, 32'h1111_1111, 4'hF, resp, lat);
        araddr = 32'h8000_0040;
        awaddr = 32'h8000_0040;
        wdata = 32'h2222_2222;
        wstrb = 4'hF;
        arvalid = 1;
        awvalid = 1;
        wvalid = 1;
        @(negedge clk);
        arvalid = 0;
        awvalid = 0;
        wvalid = 0;
        n = 0;
        while (!rvalid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("collide rdata old", rdata, 32'h1111_1111);
        check("collide bvalid together", 32'(bvalid), 1);
        rready = 1;
        bready = 1;
        @(negedge clk);
        rready = 0;
        bready = 0;
        do_read(32'h8000_0040, d, resp, lat);
        check("collide new data", d, 32'h2222_2222);

        // reset while a read response is pending
        araddr = 32'h8000_0010;
        arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("midreset rvalid pending", 32'(rvalid), 1);
        #2 rst = 1;
        #1;
        check("midreset rvalid async", 32'(rvalid), 0);
        check("midreset arready", 32'(arready), 1);
        check("midreset rdata", rdata, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_read(32'h8000_0010, d, resp, lat);
        check("midreset data survives", d, 32'hDEAD_BEEF);
        check_lat("midreset read", lat);

        // randomized traffic against a word-array model
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            do_write(BASE + 32'h100 + 32'(4 * k), model[k], 4'hF, resp, lat);
        end
        for (int t = 0; t < 100; t++) begin
            int k;
            bit ok;
            logic [31:0] a, v, mask;
            logic [3:0] s;
            k = $urandom_range(0, 17);
            ok = k < 16;
            a = ok ? BASE + 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3))
                   : (k == 16 ? BASE - 32'(4 * $urandom_range(1, 8)) : BASE + 32'h4000 + 32'(4 * $urandom_range(0, 8)));
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                s = 4'($urandom);
                do_write(a, v, s, resp, lat);
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                if (ok) model[k] = (model[k] & ~mask) | (v & mask);
                check($sformatf("rand%0d bresp", t), 32'(resp), ok ? 0 : 2);
                check_lat($sformatf("rand%0d write", t), lat);
            end else begin
                do_read(a, d, resp, lat);
                check($sformatf("rand%0d rresp", t), 32'(resp), ok ? 0 : 2);
                check($sformatf("rand%0d rdata", t), d, ok ? model[k] : 0);
                check_lat($sformatf("rand%0d read", t), lat);
            end
        end
        for (int k = 0; k < 16; k++) begin
            do_read(BASE + 32'h100 + 32'(4 * k), d, resp, lat);
            check($sformatf("final word%0d", k), d, model[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
